// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer: {minutes, sec_tens, sec_ones, tenths} with
// start/stop, lap freeze, preload, sticky expiry and an up-count wrap pulse.
module stopwatch_timer #(
    parameter int TICK_DIV = 10_000_000,
    parameter int MIN_DIG  = 1,
    localparam int DW      = 4 * (3 + MIN_DIG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          run_tog,
    input  logic          lap,
    input  logic          dir,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] disp_data,
    output logic          running,
    output logic          lap_active,
    output logic          expired,
    output logic          wrap
);

    localparam int NDIG = 3 + MIN_DIG;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] count, count_nx, snapshot, snapshot_nx;
    logic [DW-1:0] count_inc, count_dec, load_clean;
    logic [PW-1:0] prescaler, prescaler_nx;
    logic          lap_nx, wrap_nx;
    logic          inc_carry, dec_borrow, tick;

    // Digit index 2 is sec_tens (0-5); every other digit is 0-9.
    function automatic logic [3:0] dig_lim(input int i);
        return (i == 2) ? 4'd5 : 4'd9;
    endfunction

    assign tick = (state == RUN) && (prescaler == PW'(TICK_DIV - 1));

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        count_inc  = count;
        count_dec  = count;
        load_clean = load_val;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (inc_carry) begin
                if (count[4*i +: 4] == dig_lim(i)) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = dig_lim(i);
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > dig_lim(i))
                load_clean[4*i +: 4] = dig_lim(i);
        end
    end

    // Later assignments override earlier ones, giving clr > load > run_tog > tick.
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        prescaler_nx = prescaler;
        snapshot_nx  = snapshot;
        lap_nx       = lap_active;
        wrap_nx      = 1'b0;

        if (state == RUN)
            prescaler_nx = tick ? '0 : prescaler + PW'(1);

        if (tick) begin
            if (!dir) begin
                count_nx = count_inc;
                wrap_nx  = inc_carry;
            end else if (count == '0) begin
                state_nx = EXPIRED;
            end else begin
                count_nx = count_dec;
                if (count_dec == '0)
                    state_nx = EXPIRED;
            end
        end

        if (run_tog) begin
            case (state)
                IDLE:    if (!(dir && count == '0)) state_nx = RUN;
                RUN:     if (state_nx != EXPIRED) state_nx = PAUSE;
                PAUSE:   state_nx = RUN;
                default: ;
            endcase
        end

        // Snapshot takes the pre-tick count when lap coincides with a tick.
        if (lap && (state == RUN || state == PAUSE)) begin
            if (!lap_active) begin
                snapshot_nx = count;
                lap_nx      = 1'b1;
            end else begin
                lap_nx      = 1'b0;
            end
        end

        if (load && state != RUN) begin
            state_nx     = PAUSE;
            count_nx     = load_clean;
            prescaler_nx = '0;
            lap_nx       = 1'b0;
            wrap_nx      = 1'b0;
        end

        if (clr) begin
            state_nx     = IDLE;
            count_nx     = '0;
            prescaler_nx = '0;
            lap_nx       = 1'b0;
            wrap_nx      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            prescaler  <= '0;
            snapshot   <= '0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            prescaler  <= prescaler_nx;
            snapshot   <= snapshot_nx;
            lap_active <= lap_nx;
            wrap       <= wrap_nx;
        end
    end

    assign disp_data = lap_active ? snapshot : count;
    assign running   = (state == RUN);
    assign expired   = (state == EXPIRED);

endmodule
